adc_sample_hub: RTL and testbench
=================================

Name: adc_sample_hub

Overview:
Parametrised sample collector that merges the result streams of several ADC front-ends into one ordered output stream. Each source is a (RD_EN, DATA_O, CHANNEL) triple from an ADC wrapper.
- Generates a common acquisition sync strobe and a frame sequence number.
- Holds one pending sample per source and arbitrates round-robin into a FWFT FIFO.
- Presents the FIFO on a valid/ready port for downstream packing (e.g. VSI transmit).
- Sits in top between the ADC wrappers and the link logic; generalises fixed one-wrapper-per-consumer wiring to N_SRC sources.

Parameters:
N_SRC, 4, number of sample sources (1..8)
DATA_W, 24, sample width in bits
CH_W, 4, channel-number width in bits
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
SYNC_DIV, 100000, clk cycles per sync period (>= 2)

Ports:
clk  in  1  system clock; single clock domain
rst_l  in  1  reset, synchronous, active-low
enable  in  1  acquisition enable
sync_o  out  1  one-cycle acquisition strobe, broadcast to all ADC wrappers' SYNC inputs
src_rd_en  in  N_SRC  per-source one-cycle new-sample pulse
src_data  in  N_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
src_ch  in  N_SRC*CH_W  source i occupies bits [i*CH_W +: CH_W]
m_valid  out  1  output word available
m_ready  in  1  downstream accepts word
m_data  out  DATA_W  sample value
m_src  out  SW  source index; SW = max(1, clog2(N_SRC))
m_ch  out  CH_W  channel number
m_seq  out  8  frame number at sample capture
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
ovf_cnt  out  16  count of dropped samples, saturating

Behaviour:
- Reset (rst_l=0 at a clk edge): sync counter=0, frame=0, all slots empty, FIFO empty, round-robin pointer=0, ovf_cnt=0. Outputs: sync_o=0, m_valid=0, m_data/m_src/m_ch/m_seq=0, fifo_level=0. Reset mid-operation discards all pending and buffered data.
- Sync counter: runs 0..SYNC_DIV-1 while enable=1.
  - sync_o=1 for exactly the cycle the counter equals SYNC_DIV-1, then the counter wraps to 0.
  - enable=0: counter forced to 0 and sync_o=0.
  - Frame counter (8 bit) increments on the edge where sync_o=1 and wraps 255->0.
- Slot capture: source i has a one-entry slot {data, ch, seq}.
  - A src_rd_en[i]=1 sampled with enable=1 loads the slot and marks it full; seq = frame value at that edge.
  - With enable=0, src_rd_en is ignored.
- Slot overflow:
  - rd_en on a full slot that is not granted in the same cycle: new sample overwrites the old one and ovf_cnt increments (saturates at 0xFFFF).
  - rd_en on a slot granted in the same cycle: slot is reloaded with the new sample; no overflow.
  - Multiple sources overflowing in the same cycle each count (sum added, saturating).
- Arbiter: each cycle, if fifo_level < FIFO_DEPTH and at least one slot is full, grant the first full slot searching from pointer, pointer+1, ... (mod N_SRC).
  - The granted slot is pushed as {data, src index, ch, seq} and cleared.
  - pointer <= grant+1 (mod N_SRC).
  - At most one push per cycle.
  - A push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
- FIFO: first-word-fall-through.
  - m_valid = (level != 0); m_* show the head entry.
  - A pop occurs on an edge with m_valid && m_ready; the head is stable while m_valid && !m_ready.
  - Simultaneous push and pop: level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: rd_en sampled at edge t -> slot full after t -> pushed at edge t+1 (if granted) -> m_valid=1 in the cycle after edge t+1. Minimum latency is 2 cycles.
- enable=0 does not stop the arbiter or FIFO; pending slots and FIFO contents still drain.

Optional Feature:
ADC_HUB_TSTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter runs from reset (reset value 0, wraps).
  - Its value is captured into the slot together with the sample at rd_en.
  - The value is carried through the FIFO and output on an extra port m_tstamp (out, 32).
- Not defined: no counter, no m_tstamp port, FIFO width unchanged.

Test Plan:
- SYNC_DIV=10, enable=1 from reset release -> sync_o pulses on cycles 9, 19, 29; m_seq of samples after the 2nd pulse = 2; enable=0 -> no pulses and counter restarts at 0 after re-enable.
- Single source 0 rd_en with data 0x123456, ch 3, m_ready=1 -> exactly 2 cycles later m_valid=1, m_data=0x123456, m_src=0, m_ch=3, for one cycle.
- All 4 sources rd_en in the same cycle with data 0xA0..0xA3 -> outputs in order src 0,1,2,3 on 4 consecutive cycles. Repeat after the last grant was src 1 -> order 2,3,0,1.
- m_ready=0, 20 samples via round-robin, FIFO_DEPTH=16 -> fifo_level reaches 16, further samples wait in slots. Repeated rd_en on a waiting slot -> ovf_cnt increments by 1 each. Releasing m_ready drains in FIFO order without loss of the 16 buffered words.
- rd_en on source 2 in the same cycle it is granted -> both old and new samples appear at the output, ovf_cnt unchanged.
- Assert rst_l=0 for 1 cycle with FIFO level 7 and 2 full slots -> next cycle m_valid=0, fifo_level=0, ovf_cnt=0, sync counter restarts at 0.

Source files
------------

// File: rtl/adc_sample_hub.sv
// Round-robin collector of N_SRC ADC sample streams into one FWFT FIFO.
// Define ADC_HUB_TSTAMP_EN to carry a 32-bit cycle timestamp (m_tstamp).
module adc_sample_hub #(
  parameter int N_SRC = 4,
  parameter int DATA_W = 24,
  parameter int CH_W = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_DIV = 100000,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    enable,
  output logic                    sync_o,
  input  logic [N_SRC-1:0]        src_rd_en,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC*CH_W-1:0]   src_ch,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic [SW-1:0]           m_src,
  output logic [CH_W-1:0]         m_ch,
  output logic [7:0]              m_seq,
  output logic [LW-1:0]           fifo_level,
`ifdef ADC_HUB_TSTAMP_EN
  output logic [31:0]             m_tstamp,
`endif
  output logic [15:0]             ovf_cnt
);

  localparam int CNT_W = $clog2(SYNC_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
`ifdef ADC_HUB_TSTAMP_EN
    logic [31:0]       ts;
`endif
    logic [DATA_W-1:0] data;
    logic [SW-1:0]     src;
    logic [CH_W-1:0]   ch;
    logic [7:0]        seq;
  } ent_t;

  logic [CNT_W-1:0] cnt;
  logic [7:0]       frame;
  logic             tc;

  assign tc = (cnt == CNT_W'(SYNC_DIV - 1));
  assign sync_o = enable && tc;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt <= '0;
      frame <= '0;
    end else begin
      if (!enable || tc) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);
      if (sync_o) frame <= frame + 8'd1;
    end
  end

`ifdef ADC_HUB_TSTAMP_EN
  logic [31:0] tcnt;

  always_ff @(posedge clk) begin
    if (!rst_l) tcnt <= '0;
    else tcnt <= tcnt + 32'd1;
  end
`endif

  ent_t             slot [N_SRC];
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] cap;
  logic [N_SRC-1:0] hit;
  logic [N_SRC-1:0] ovf_vec;
  logic [3:0]       ovf_add;
  logic [16:0]      ovf_sum;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    idx;
  logic [SW-1:0]    gnt;
  logic             gnt_vld;

  ent_t             mem [FIFO_DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [LW-1:0]    level;
  logic             push;
  logic             pop;
  ent_t             head;

  assign cap = enable ? src_rd_en : '0;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr) + k) % N_SRC);
      if (full[idx]) begin
        gnt_vld = 1'b1;
        gnt = idx;
      end
    end
    if (level == LW'(FIFO_DEPTH)) gnt_vld = 1'b0;
    hit = '0;
    if (gnt_vld) hit[gnt] = 1'b1;
    ovf_vec = cap & full & ~hit;
    ovf_add = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ovf_add = ovf_add + 4'(ovf_vec[i]);
    end
    ovf_sum = {1'b0, ovf_cnt} + {13'd0, ovf_add};
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      full <= '0;
      ptr <= '0;
      ovf_cnt <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cap[i]) full[i] <= 1'b1;
        else if (hit[i]) full[i] <= 1'b0;
      end
      if (gnt_vld) begin
        if (gnt == SW'(N_SRC - 1)) ptr <= '0;
        else ptr <= gnt + SW'(1);
      end
      ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (cap[i]) begin
        slot[i].data <= src_data[i*DATA_W +: DATA_W];
        slot[i].src <= SW'(i);
        slot[i].ch <= src_ch[i*CH_W +: CH_W];
        slot[i].seq <= frame;
`ifdef ADC_HUB_TSTAMP_EN
        slot[i].ts <= tcnt;
`endif
      end
    end
  end

  assign push = gnt_vld;
  assign pop = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= slot[gnt];
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push && !pop) level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  assign head = mem[rp];
  assign m_valid = (level != '0);
  assign fifo_level = level;
  assign m_data = m_valid ? head.data : '0;
  assign m_src = m_valid ? head.src : '0;
  assign m_ch = m_valid ? head.ch : '0;
  assign m_seq = m_valid ? head.seq : '0;
`ifdef ADC_HUB_TSTAMP_EN
  assign m_tstamp = m_valid ? head.ts : '0;
`endif

endmodule

// File: tb/tb_adc_sample_hub.sv
// Directed and random checks of adc_sample_hub against a queue-based model.
// Runs with SYNC_DIV=10 and the default 4-source, 16-deep configuration.
module tb_adc_sample_hub;
  localparam int N = 4;
  localparam int DW = 24;
  localparam int CW = 4;
  localparam int FD = 16;
  localparam int SD = 10;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic enable = 1'b0;
  logic m_ready = 1'b0;
  logic [N-1:0] src_rd_en = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N*CW-1:0] src_ch = '0;
  logic sync_o;
  logic m_valid;
  logic [DW-1:0] m_data;
  logic [1:0] m_src;
  logic [CW-1:0] m_ch;
  logic [7:0] m_seq;
  logic [4:0] fifo_level;
  logic [15:0] ovf_cnt;
`ifdef ADC_HUB_TSTAMP_EN
  logic [31:0] m_tstamp;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  adc_sample_hub #(
    .N_SRC(N), .DATA_W(DW), .CH_W(CW),
    .FIFO_DEPTH(FD), .SYNC_DIV(SD)
  ) dut (
    .clk(clk), .rst_l(rst_l), .enable(enable),
    .sync_o(sync_o), .src_rd_en(src_rd_en),
    .src_data(src_data), .src_ch(src_ch),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_src(m_src), .m_ch(m_ch),
    .m_seq(m_seq), .fifo_level(fifo_level),
`ifdef ADC_HUB_TSTAMP_EN
    .m_tstamp(m_tstamp),
`endif
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int s;
    logic [CW-1:0] c;
    int q;
  } ent_t;

  ent_t fq[$];
  ent_t mslot[N];
  bit mfull[N];
  int mcnt = 0;
  int mframe = 0;
  int mptr = 0;
  int movf = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs now applied.
  task automatic model_step();
    bit sync;
    int g;
    if (!rst_l) begin
      mcnt = 0;
      mframe = 0;
      mptr = 0;
      movf = 0;
      fq.delete();
      for (int i = 0; i < N; i++) mfull[i] = 0;
    end else begin
      sync = enable && (mcnt == SD - 1);
      g = -1;
      if (fq.size() < FD) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && mfull[(mptr + k) % N]) g = (mptr + k) % N;
        end
      end
      if (fq.size() != 0 && m_ready) void'(fq.pop_front());
      if (g >= 0) begin
        fq.push_back(mslot[g]);
        mfull[g] = 0;
        mptr = (g + 1) % N;
      end
      if (enable) begin
        for (int i = 0; i < N; i++) begin
          if (src_rd_en[i]) begin
            if (mfull[i]) movf = (movf < 16'hFFFF) ? movf + 1 : movf;
            mslot[i].d = src_data[i*DW +: DW];
            mslot[i].s = i;
            mslot[i].c = src_ch[i*CW +: CW];
            mslot[i].q = mframe;
            mfull[i] = 1;
          end
        end
      end
      if (sync) mframe = (mframe + 1) % 256;
      mcnt = (!enable || sync) ? 0 : mcnt + 1;
    end
  endtask

  task automatic model_check();
    ent_t h;
    h = '{d: '0, s: 0, c: '0, q: 0};
    if (fq.size() != 0) h = fq[0];
    chk("sync_o", 32'(sync_o), 32'(enable && (mcnt == SD - 1)));
    chk("m_valid", 32'(m_valid), 32'(fq.size() != 0));
    chk("m_data", 32'(m_data), 32'(h.d));
    chk("m_src", 32'(m_src), h.s);
    chk("m_ch", 32'(m_ch), 32'(h.c));
    chk("m_seq", 32'(m_seq), h.q);
    chk("fifo_level", 32'(fifo_level), fq.size());
    chk("ovf_cnt", 32'(ovf_cnt), movf);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic put(int i, logic [DW-1:0] d, logic [CW-1:0] c);
    src_rd_en[i] = 1'b1;
    src_data[i*DW +: DW] = d;
    src_ch[i*CW +: CW] = c;
  endtask

  initial begin
    logic [DW-1:0] sd [20];
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int nout;

    enable = 1'b1;
    m_ready = 1'b1;
    rst_l = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_sync", 32'(sync_o), 0);
    rst_l = 1'b1;

    for (int c = 0; c < 32; c++) begin
      chk("sync_period", 32'(sync_o), 32'((c % 10) == 9));
      if (c == 21) put(1, 24'h00ABCD, 4'd5);
      if (c == 22) src_rd_en = '0;
      if (c == 23) begin
        chk("seq_valid", 32'(m_valid), 1);
        chk("seq_frame", 32'(m_seq), 2);
        chk("seq_src", 32'(m_src), 1);
      end
      tick();
    end

    enable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("sync_off", 32'(sync_o), 0);
    end
    enable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("sync_restart", 32'(sync_o), 32'(c == 9));
    end

    put(0, 24'h123456, 4'd3);
    tick();
    src_rd_en = '0;
    chk("lat_t1", 32'(m_valid), 0);
    tick();
    chk("lat_valid", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 32'h123456);
    chk("lat_src", 32'(m_src), 0);
    chk("lat_ch", 32'(m_ch), 3);
    tick();
    chk("lat_once", 32'(m_valid), 0);

    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < N; i++) put(i, DW'(8'hA0 + i), CW'(i));
    tick();
    src_rd_en = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr_src", 32'(m_src), k);
      chk("rr_data", 32'(m_data), 32'h0A0 + k);
    end
    tick();
    chk("rr_empty", 32'(m_valid), 0);

    put(1, 24'h000055, 4'd1);
    tick();
    src_rd_en = '0;
    tick();
    tick();
    for (int i = 0; i < N; i++) put(i, DW'(8'hB0 + i), CW'(i));
    tick();
    src_rd_en = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr2_src", 32'(m_src), (k + 2) % N);
      chk("rr2_data", 32'(m_data), 32'h0B0 + (k + 2) % N);
    end
    tick();
    chk("rr2_empty", 32'(m_valid), 0);

    m_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      src_rd_en = '0;
      sd[k] = DW'($urandom);
      put(k % N, sd[k], CW'(k));
      tick();
    end
    src_rd_en = '0;
    chk("full_level", 32'(fifo_level), 16);
    for (int k = 0; k < 3; k++) begin
      put(2, DW'($urandom), 4'd2);
      tick();
    end
    src_rd_en = '0;
    chk("ovf_three", 32'(ovf_cnt), 3);
    chk("full_hold", 32'(fifo_level), 16);
    m_ready = 1'b1;
    nout = 0;
    for (int k = 0; k < 25; k++) begin
      if (m_valid) begin
        if (nout < 16) chk("drain_data", 32'(m_data), 32'(sd[nout]));
        nout++;
      end
      tick();
    end
    chk("drain_count", nout, 20);

    x = DW'($urandom);
    y = DW'($urandom);
    put(2, x, 4'd7);
    tick();
    put(2, y, 4'd8);
    tick();
    src_rd_en = '0;
    chk("reload_old", 32'(m_data), 32'(x));
    chk("reload_src", 32'(m_src), 2);
    tick();
    chk("reload_new", 32'(m_data), 32'(y));
    chk("reload_valid", 32'(m_valid), 1);
    tick();
    chk("reload_empty", 32'(m_valid), 0);
    chk("reload_ovf", 32'(ovf_cnt), 3);

    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < N; i++) begin
        src_rd_en[i] = ($urandom_range(3) == 0);
        src_data[i*DW +: DW] = DW'($urandom);
        src_ch[i*CW +: CW] = CW'($urandom);
      end
      m_ready = ($urandom_range(2) != 0);
      enable = ($urandom_range(9) != 0);
      tick();
    end
    src_rd_en = '0;
    enable = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    chk("rand_drained", 32'(m_valid), 0);

    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      put(3, DW'($urandom), 4'd1);
      tick();
    end
    src_rd_en = '0;
    for (int i = 0; i < 3; i++) put(i, DW'($urandom), 4'd2);
    tick();
    src_rd_en = '0;
    tick();
    chk("pre_rst_level", 32'(fifo_level), 7);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_ovf", 32'(ovf_cnt), 0);
    chk("mid_rst_sync", 32'(sync_o), 0);
    m_ready = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk("post_rst_sync", 32'(sync_o), 32'(c == 9));
      chk("post_rst_empty", 32'(m_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
